// File: rtl/cmd_unpacker_pkg.sv
// ----------------------------------------------------------------------------
// cmd_unpacker_pkg
// Shared definitions for the command unpacker and the downstream executor:
//   - state_e      : unpacker FSM state encodings (HEADER, ARGS, SKIP, OUTPUT)
//   - NARGS_*      : header bit positions of the argument count
//   - OPCODE_*     : header bit positions of the opcode
//   - hdr_nargs()  : extract the argument count from a header byte
//   - hdr_opcode() : extract the opcode from a header byte
// ----------------------------------------------------------------------------
package cmd_unpacker_pkg;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_ARGS   = 2'd1,
        ST_SKIP   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    localparam int NARGS_MSB  = 7;
    localparam int NARGS_LSB  = 5;
    localparam int OPCODE_MSB = 4;
    localparam int OPCODE_LSB = 0;

    function automatic logic [2:0] hdr_nargs(input logic [7:0] header);
        return header[NARGS_MSB:NARGS_LSB];
    endfunction

    function automatic logic [4:0] hdr_opcode(input logic [7:0] header);
        return header[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/cmd_unpacker_idle_timer.sv
// ----------------------------------------------------------------------------
// cmd_unpacker_idle_timer
// Idle-cycle counter used by cmd_unpacker to abort a command whose argument
// bytes stop arriving. Only compiled when CMD_TIMEOUT_EN is defined; in the
// default build this file contributes nothing.
//
// Parameters:
//   Cycles : terminal count; expired fires on the cycle the count reaches Cycles-1
//   Width  : counter width, must hold Cycles-1
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset (clears the count)
//   clear   in  force the count back to zero (dominates enable)
//   enable  in  count this cycle
//   expired out combinational terminal-count pulse (enable high and count at end)
// ----------------------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
module cmd_unpacker_idle_timer #(
    parameter int Cycles = 1024,
    parameter int Width  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [Width-1:0] Terminal = Width'(Cycles - 1);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Clear wins over enable so a pop or state change in the same cycle
    // always restarts the idle window from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + Width'(1);
        end
    end

    assign expired = enable && (count_q == Terminal);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/cmd_unpacker.sv
// ----------------------------------------------------------------------------
// cmd_unpacker
// Pulls bytes from an upstream first-word-fall-through FIFO and assembles
// variable-length commands (one header byte, 0..7 argument bytes), then
// presents each complete command on a valid/ready interface.
// Header layout: [7:5] argument count, [4:0] opcode.
// Commands with more arguments than MaxArgs are drained and dropped, and
// cmd_error pulses once.
//
// Optional feature: define CMD_TIMEOUT_EN to abort a command that stalls
// mid-arguments for TimeoutCycles idle cycles (cmd_error pulses, the partial
// command is dropped). Without it ARGS/SKIP wait for data indefinitely.
//
// Parameters:
//   MaxArgs       : argument bytes held per command (1..7)
//   TimeoutCycles : idle-cycle abort threshold (CMD_TIMEOUT_EN only)
//   TimeoutWidth  : idle counter width (CMD_TIMEOUT_EN only)
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   fifo_empty   in   upstream FIFO empty; fifo_data valid when low
//   fifo_data    in   upstream FIFO head byte
//   fifo_read_en out  pop the head byte this cycle (combinational)
//   cmd_valid    out  command presented on cmd_* outputs
//   cmd_ready    in   downstream accepts when high together with cmd_valid
//   cmd_opcode   out  header opcode
//   cmd_nargs    out  header argument count
//   cmd_args     out  arguments, first in the top byte, unused bytes zero
//   cmd_error    out  one-cycle pulse on oversize command or timeout abort
// ----------------------------------------------------------------------------
module cmd_unpacker
    import cmd_unpacker_pkg::*;
#(
    parameter int MaxArgs       = 4,
    parameter int TimeoutCycles = 1024,
    parameter int TimeoutWidth  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_read_en,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [4:0]           cmd_opcode,
    output logic [2:0]           cmd_nargs,
    output logic [8*MaxArgs-1:0] cmd_args,
    output logic                 cmd_error
);

    localparam logic [2:0] MaxArgs3 = 3'(MaxArgs);

    state_e               state_q;
    state_e               state_d;
    logic [4:0]           opcode_q;
    logic [4:0]           opcode_d;
    logic [2:0]           nargs_q;
    logic [2:0]           nargs_d;
    logic [8*MaxArgs-1:0] args_q;
    logic [8*MaxArgs-1:0] args_d;
    logic [2:0]           remaining_q;
    logic [2:0]           remaining_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 error_q;
    logic                 error_d;

    logic                 pop;
    logic [2:0]           slot;
    logic                 timeout_hit;

    // A byte is popped and consumed in the same cycle whenever the FSM is
    // collecting bytes and the FIFO has one; nothing is popped during reset.
    assign pop          = !reset && !fifo_empty && (state_q != ST_OUTPUT);
    assign fifo_read_en = pop;

    // Argument slot counts up from 0 as remaining counts down from nargs,
    // so it stays below nargs <= MaxArgs.
    assign slot = nargs_q - remaining_q;

`ifdef CMD_TIMEOUT_EN
    logic timer_active;
    logic timer_enable;
    logic timer_clear;

    // Idle time only accumulates while waiting for argument bytes; any pop,
    // any state change, or being outside ARGS/SKIP restarts the window.
    assign timer_active = (state_q == ST_ARGS) || (state_q == ST_SKIP);
    assign timer_enable = timer_active && fifo_empty;
    assign timer_clear  = pop || (state_d != state_q) || !timer_active;

    cmd_unpacker_idle_timer #(
        .Cycles (TimeoutCycles),
        .Width  (TimeoutWidth)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^{TimeoutCycles, TimeoutWidth};
`endif

    // Next-state and datapath: header decode, argument placement, skip
    // draining and the output handshake. Outputs are registered from the
    // next-state values so cmd_valid rises together with the OUTPUT state.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        nargs_d     = nargs_q;
        args_d      = args_q;
        remaining_d = remaining_q;
        error_d     = 1'b0;

        unique case (state_q)
            ST_HEADER: begin
                if (pop) begin
                    opcode_d    = hdr_opcode(fifo_data);
                    nargs_d     = hdr_nargs(fifo_data);
                    args_d      = '0;
                    remaining_d = hdr_nargs(fifo_data);
                    if (hdr_nargs(fifo_data) == 3'd0) begin
                        state_d = ST_OUTPUT;
                    end else if (hdr_nargs(fifo_data) > MaxArgs3) begin
                        state_d = ST_SKIP;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_ARGS;
                    end
                end
            end

            ST_ARGS: begin
                if (pop) begin
                    for (int i = 0; i < MaxArgs; i++) begin
                        if (slot == 3'(i)) begin
                            args_d[8*(MaxArgs-1-i) +: 8] = fifo_data;
                        end
                    end
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = ST_OUTPUT;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_HEADER;
                    error_d = 1'b1;
                end
            end

            ST_SKIP: begin
                if (pop) begin
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = ST_HEADER;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_HEADER;
                    error_d = 1'b1;
                end
            end

            ST_OUTPUT: begin
                if (cmd_ready) begin
                    state_d = ST_HEADER;
                end
            end

            default: begin
                state_d = ST_HEADER;
            end
        endcase

        valid_d = (state_d == ST_OUTPUT);
    end

    // State and registered outputs; reset drops any partial command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HEADER;
            opcode_q    <= '0;
            nargs_q     <= '0;
            args_q      <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            nargs_q     <= nargs_d;
            args_q      <= args_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_opcode = opcode_q;
    assign cmd_nargs  = nargs_q;
    assign cmd_args   = args_q;
    assign cmd_error  = error_q;

endmodule

// File: tb/tb_cmd_unpacker.sv
// ----------------------------------------------------------------------------
// tb_cmd_unpacker
// Self-checking bench for cmd_unpacker (MaxArgs=4, TimeoutCycles=16).
// A queue models the upstream FWFT FIFO: its head drives fifo_data, and a
// byte is removed when fifo_read_en was high across a rising edge.
// Accepted commands are captured into a queue for comparison.
// The timeout sequence is built when CMD_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_cmd_unpacker;

    localparam int MaxArgs  = 4;
    localparam int NumVecs  = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_read_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_opcode;
    logic [2:0]  cmd_nargs;
    logic [31:0] cmd_args;
    logic        cmd_error;

    always #5 clk = ~clk;

    cmd_unpacker #(
        .MaxArgs       (MaxArgs),
        .TimeoutCycles (16),
        .TimeoutWidth  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_nargs    (cmd_nargs),
        .cmd_args     (cmd_args),
        .cmd_error    (cmd_error)
    );

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  nargs;
        logic [31:0] args;
    } cmd_t;

    typedef struct {
        logic [0:9][7:0] bytes;
        int              nbytes;
        cmd_t            exp_cmd;
        int              exp_errors;
        int              exp_cycles;
    } vec_t;

    logic [7:0] fifo_q[$];
    cmd_t       got_q[$];
    vec_t       vecs[NumVecs];

    int checks       = 0;
    int errors       = 0;
    int pop_count    = 0;
    int error_pulses = 0;

    function automatic void refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock: sample pop/handshake just before the edge, then update the
    // FIFO model and capture accepted commands and error pulses after it.
    task automatic run_cycle();
        logic       pop_now;
        logic       accept_now;
        cmd_t       cmd_now;
        logic [7:0] popped;
        #1;
        pop_now    = fifo_read_en;
        accept_now = cmd_valid && cmd_ready;
        cmd_now    = {cmd_opcode, cmd_nargs, cmd_args};
        @(posedge clk);
        #1;
        if (pop_now) begin
            if (fifo_q.size() > 0) begin
                popped = fifo_q.pop_front();
            end
            pop_count++;
        end
        if (accept_now) begin
            got_q.push_back(cmd_now);
        end
        if (cmd_error) begin
            error_pulses++;
        end
        refresh_fifo();
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.nbytes; i++) begin
            push_byte(v.bytes[i]);
        end
    endtask

    task automatic wait_cmds(input int count, input int limit, output int cycles);
        cycles = 0;
        while (got_q.size() < count && cycles < limit) begin
            run_cycle();
            cycles++;
        end
    endtask

    task automatic start_section();
        got_q.delete();
        pop_count    = 0;
        error_pulses = 0;
    endtask

    initial begin
        int   cycles;
        int   unstable;
        int   rd_seen;
        int   pops_before;
        cmd_t snapshot;

        vecs[0] = '{{8'h05, 72'h0}, 1, {5'd5, 3'd0, 32'h00000000}, 0, 2};
        vecs[1] = '{{8'h63, 8'hAA, 8'hBB, 8'hCC, 48'h0}, 4,
                    {5'd3, 3'd3, 32'hAABBCC00}, 0, 5};
        vecs[2] = '{{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h22, 8'h11, 16'h0}, 8,
                    {5'd2, 3'd1, 32'h11000000}, 1, 9};
        vecs[3] = '{{8'h9F, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 40'h0}, 5,
                    {5'd31, 3'd4, 32'hDEADBEEF}, 0, 6};
        vecs[4] = '{{8'hE0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1A, 8'h00}, 9,
                    {5'd26, 3'd0, 32'h00000000}, 1, 10};
        vecs[5] = '{{8'h25, 8'h5A, 64'h0}, 2, {5'd5, 3'd1, 32'h5A000000}, 0, 3};
        vecs[6] = '{{8'h40, 8'h12, 8'h34, 56'h0}, 3, {5'd0, 3'd2, 32'h12340000}, 0, 4};

        reset     = 1'b1;
        cmd_ready = 1'b1;
        refresh_fifo();
        run_cycle();
        checkOutput("reset valid", 64'(cmd_valid), 64'd0);
        checkOutput("reset cmd", 64'({cmd_opcode, cmd_nargs, cmd_args}), 64'd0);
        checkOutput("reset error", 64'(cmd_error), 64'd0);
        checkOutput("reset read_en", 64'(fifo_read_en), 64'd0);
        run_cycle();
        reset = 1'b0;

        // Table-driven commands with continuous data and cmd_ready high.
        for (int v = 0; v < NumVecs; v++) begin
            start_section();
            applyStimulus(vecs[v]);
            wait_cmds(1, 40, cycles);
            checkOutput($sformatf("vec%0d accepted", v), 64'(got_q.size()), 64'd1);
            if (got_q.size() > 0) begin
                checkOutput($sformatf("vec%0d cmd", v), 64'(got_q[0]), 64'(vecs[v].exp_cmd));
            end
            checkOutput($sformatf("vec%0d cycles", v), 64'(cycles), 64'(vecs[v].exp_cycles));
            checkOutput($sformatf("vec%0d error pulses", v), 64'(error_pulses),
                        64'(vecs[v].exp_errors));
            checkOutput($sformatf("vec%0d pops", v), 64'(pop_count), 64'(vecs[v].nbytes));
            checkOutput($sformatf("vec%0d valid after accept", v), 64'(cmd_valid), 64'd0);
        end

        // Backpressure: command held stable, nothing popped while stalled.
        start_section();
        cmd_ready = 1'b0;
        push_byte(8'h63);
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        cycles = 0;
        while (!cmd_valid && cycles < 20) begin
            run_cycle();
            cycles++;
        end
        checkOutput("stall valid", 64'(cmd_valid), 64'd1);
        snapshot = {cmd_opcode, cmd_nargs, cmd_args};
        push_byte(8'h05);
        unstable    = 0;
        rd_seen     = 0;
        pops_before = pop_count;
        repeat (10) begin
            run_cycle();
            if ({cmd_opcode, cmd_nargs, cmd_args} != snapshot || !cmd_valid) unstable++;
            if (fifo_read_en) rd_seen++;
        end
        checkOutput("stall outputs stable", 64'(unstable), 64'd0);
        checkOutput("stall read_en", 64'(rd_seen), 64'd0);
        checkOutput("stall pops", 64'(pop_count - pops_before), 64'd0);
        checkOutput("stall no accept", 64'(got_q.size()), 64'd0);
        cmd_ready = 1'b1;
        wait_cmds(2, 20, cycles);
        checkOutput("stall accepted", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            checkOutput("stall cmd", 64'(got_q[0]), 64'({5'd3, 3'd3, 32'hAABBCC00}));
            checkOutput("stall next cmd", 64'(got_q[1]), 64'({5'd5, 3'd0, 32'h0}));
        end

        // Empty FIFO between argument bytes stalls without losing state.
        start_section();
        unstable = 0;
        push_byte(8'h42);
        run_cycle();
        repeat (3) begin
            run_cycle();
            if (cmd_valid || fifo_read_en) unstable++;
        end
        push_byte(8'h9C);
        run_cycle();
        repeat (3) begin
            run_cycle();
            if (cmd_valid || fifo_read_en) unstable++;
        end
        push_byte(8'h3E);
        wait_cmds(1, 10, cycles);
        checkOutput("gap idle behaviour", 64'(unstable), 64'd0);
        checkOutput("gap accepted", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            checkOutput("gap cmd", 64'(got_q[0]), 64'({5'd2, 3'd2, 32'h9C3E0000}));
        end

        // Reset in the middle of ARGS discards the partial command.
        start_section();
        push_byte(8'h63);
        push_byte(8'hAA);
        run_cycle();
        run_cycle();
        reset = 1'b1;
        run_cycle();
        checkOutput("midreset cmd", 64'({cmd_opcode, cmd_nargs, cmd_args}), 64'd0);
        checkOutput("midreset flags", 64'({cmd_valid, cmd_error, fifo_read_en}), 64'd0);
        reset = 1'b0;
        push_byte(8'h05);
        wait_cmds(1, 10, cycles);
        checkOutput("midreset next accepted", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            checkOutput("midreset next cmd", 64'(got_q[0]), 64'({5'd5, 3'd0, 32'h0}));
        end

`ifdef CMD_TIMEOUT_EN
        // Sixteen idle cycles mid-arguments abort the command.
        start_section();
        push_byte(8'h44);
        push_byte(8'h01);
        run_cycle();
        run_cycle();
        repeat (15) run_cycle();
        checkOutput("timeout early", 64'(error_pulses), 64'd0);
        run_cycle();
        checkOutput("timeout pulse", 64'(cmd_error), 64'd1);
        run_cycle();
        checkOutput("timeout pulse count", 64'(error_pulses), 64'd1);
        checkOutput("timeout no cmd", 64'(got_q.size()), 64'd0);
        push_byte(8'h07);
        wait_cmds(1, 10, cycles);
        checkOutput("timeout next accepted", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            checkOutput("timeout next cmd", 64'(got_q[0]), 64'({5'd7, 3'd0, 32'h0}));
        end
`else
        // Without the timeout a stalled command simply waits for its data.
        start_section();
        push_byte(8'h44);
        push_byte(8'h01);
        run_cycle();
        run_cycle();
        repeat (40) run_cycle();
        checkOutput("long wait no error", 64'(error_pulses), 64'd0);
        checkOutput("long wait no cmd", 64'(got_q.size()), 64'd0);
        push_byte(8'h77);
        wait_cmds(1, 10, cycles);
        checkOutput("long wait accepted", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            checkOutput("long wait cmd", 64'(got_q[0]), 64'({5'd4, 3'd2, 32'h01770000}));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
